// File: rtl/axi4lite_pkg.sv
// Shared response codes and sizing helpers for the AXI4-Lite register bank.
package axi4lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Width of the word index once the byte-offset bits are dropped.
    function automatic int idx_width(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi4lite_wjoin.sv
// Joins independently arriving AW and W beats into one commit strobe and owns the B channel.
module axi4lite_wjoin
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic                    bready_i,
    output logic                    bvalid_o,
    output resp_t                   bresp_o,
    input  logic                    err_i,
    output logic                    cmt_o,
    output logic [ADDR_WIDTH-1:0]   cmt_addr_o,
    output logic [DATA_WIDTH-1:0]   cmt_data_o,
    output logic [DATA_WIDTH/8-1:0] cmt_strb_o
);

    logic                    aw_held_q, w_held_q, bvalid_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    resp_t                   bresp_q;
    logic                    aw_hs, w_hs;

    assign awready_o = en_i && !aw_held_q && !bvalid_q;
    assign wready_o  = en_i && !w_held_q && !bvalid_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    // Latches stay set through the B phase so nothing new is joined until B completes.
    assign cmt_o      = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    assign cmt_addr_o = aw_held_q ? aw_addr_q : awaddr_i;
    assign cmt_data_o = w_held_q ? w_data_q : wdata_i;
    assign cmt_strb_o = w_held_q ? w_strb_q : wstrb_i;

    assign bvalid_o = bvalid_q;
    assign bresp_o  = bresp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= awaddr_i;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
            if (cmt_o) begin
                bvalid_q <= 1'b1;
                bresp_q  <= err_i ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && bready_i) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4lite_regbank.sv
// Parametrised AXI4-Lite register bank: RW, read-only status and self-clearing pulse registers.
module axi4lite_regbank
    import axi4lite_pkg::*;
#(
    parameter int                  NUM_REGS   = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = 'hC0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = 'h20
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int OFFS   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = idx_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                                alive_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]                 wr_pulse_q, hit;
    logic                                cmt, wr_err;
    logic [ADDR_WIDTH-1:0]               cmt_addr;
    logic [DATA_WIDTH-1:0]               cmt_data;
    logic [STRB_W-1:0]                   cmt_strb;
    logic [IDX_W-1:0]                    widx, ridx;
    logic                                rvalid_q, rerr_d, ar_hs;
    logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
    resp_t                               rresp_q, bresp;
    logic                                unused_sig;

    // Handshakes are held off until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) alive_q <= 1'b0;
        else          alive_q <= 1'b1;
    end

    axi4lite_wjoin #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wjoin (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .en_i       (alive_q),
        .awaddr_i   (AWADDR),
        .awvalid_i  (AWVALID),
        .awready_o  (AWREADY),
        .wdata_i    (WDATA),
        .wstrb_i    (WSTRB),
        .wvalid_i   (WVALID),
        .wready_o   (WREADY),
        .bready_i   (BREADY),
        .bvalid_o   (BVALID),
        .bresp_o    (bresp),
        .err_i      (wr_err),
        .cmt_o      (cmt),
        .cmt_addr_o (cmt_addr),
        .cmt_data_o (cmt_data),
        .cmt_strb_o (cmt_strb)
    );

    assign BRESP = bresp;
    assign widx  = cmt_addr[ADDR_WIDTH-1:OFFS];
    assign ridx  = ARADDR[ADDR_WIDTH-1:OFFS];

    always_comb begin
        wr_err = 1'b1;
        hit    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == IDX_W'(i)) begin
                wr_err = RO_MASK[i];
                hit[i] = cmt && !RO_MASK[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hit[i]) begin
                    for (int b = 0; b < STRB_W; b++)
                        if (cmt_strb[b]) regs_q[i][8*b +: 8] <= cmt_data[8*b +: 8];
                end else if (PULSE_MASK[i]) begin
                    regs_q[i] <= '0;
                end
            end
        end
    end

    assign reg_out  = regs_q;
    assign wr_pulse = wr_pulse_q;

    assign ARREADY = alive_q && !rvalid_q;
    assign ar_hs   = ARVALID && ARREADY;

    // regs_q is sampled before this edge's write lands, so a colliding read sees the old value.
    always_comb begin
        rdata_d = '0;
        rerr_d  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rerr_d  = 1'b0;
                rdata_d = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rerr_d ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

    assign unused_sig = ^{AWPROT, ARPROT, ARADDR[OFFS-1:0], cmt_addr[OFFS-1:0], status_in};

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed self-checking bench for axi4lite_regbank with default parameters.
module tb_axi4lite_regbank;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [7:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [7:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [255:0] reg_out;
    logic [255:0] status_in = '0;
    logic [7:0]   wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axi4lite_regbank dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    // W is presented immediately, AW after aw_dly cycles; BREADY held low for bdly cycles.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int bdly,
                             output logic [1:0] r, output int lat, output logic [7:0] pw,
                             output logic [7:0] pw2, output logic [255:0] rout,
                             output logic [255:0] rout2, output bit stable);
        bit awd = 0, wd = 0, hs_aw, hs_w;
        int n = 0;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!(awd && wd) && n < 30) begin
            if (n == aw_dly && !awd) AWVALID = 1'b1;
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(negedge ACLK);
            if (hs_aw) begin AWVALID = 1'b0; awd = 1; end
            if (hs_w)  begin WVALID = 1'b0;  wd = 1;  end
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        if (!(awd && wd)) begin
            n_tests++; n_fail++;
            $display("FAIL wr_handshake_timeout addr=%h", a);
        end
        lat = 0;
        while (!BVALID && lat < 30) begin @(negedge ACLK); lat++; end
        r = BRESP; pw = wr_pulse; rout = reg_out;
        stable = 1; pw2 = '0; rout2 = '0;
        for (int k = 0; k < bdly; k++) begin
            @(negedge ACLK);
            if (k == 0) begin pw2 = wr_pulse; rout2 = reg_out; end
            if (!(BVALID && BRESP == r && !AWREADY && !WREADY)) stable = 0;
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        if (bdly == 0) begin pw2 = wr_pulse; rout2 = reg_out; end
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        bit hs = 0;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        while (!hs && n < 30) begin
            hs = ARVALID && ARREADY;
            @(negedge ACLK);
            n++;
        end
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 30) begin @(negedge ACLK); n++; end
        if (!RVALID) begin
            n_tests++; n_fail++;
            $display("FAIL rd_timeout addr=%h", a);
        end
        d = RDATA; r = RRESP;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        n_tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshake got=%b want=00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        n_tests++;
        if (reg_out !== '0 || wr_pulse !== '0 || RDATA !== '0 || BRESP !== 2'b00 || RRESP !== 2'b00) begin
            n_fail++; $display("FAIL reset_state reg_out=%h wr_pulse=%h rdata=%h", reg_out, wr_pulse, RDATA);
        end
        @(negedge ACLK); ARESETN = 1'b1;
        @(negedge ACLK);
        n_tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_reset got=%b want=111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(8'(4*i), 32'(i+1), 4'hF, 0, 0, r, lat, pw, pw2, ro, ro2, st);
            n_tests++;
            if (r !== 2'b00 || lat != 0) begin
                n_fail++; $display("FAIL basic_bresp[%0d] got=%b lat=%0d want=00 lat=0", i, r, lat);
            end
            n_tests++;
            if (pw !== 8'(1 << i) || pw2 !== 8'h00) begin
                n_fail++; $display("FAIL basic_pulse[%0d] got=%h then %h want=%h then 00", i, pw, pw2, 8'(1 << i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(4*i), d, r);
            n_tests++;
            if (d !== 32'(i+1) || r !== 2'b00) begin
                n_fail++; $display("FAIL basic_read[%0d] got=%h/%b want=%h/00", i, d, r, 32'(i+1));
            end
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        axi_write(8'h10, 32'hDEADBEEF, 4'hF, 3, 0, r, lat, pw, pw2, ro, ro2, st);
        n_tests++;
        if (lat != 0 || r !== 2'b00 || pw !== 8'h10) begin
            n_fail++; $display("FAIL w_first_b lat=%0d resp=%b pulse=%h want 0/00/10", lat, r, pw);
        end
        axi_read(8'h10, d, r);
        n_tests++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            n_fail++; $display("FAIL w_first_read got=%h want=deadbeef", d);
        end
    endtask

    task automatic test_strb();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        axi_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        axi_write(8'h01, 32'h12345678, 4'b0101, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        axi_read(8'h00, d, r);
        n_tests++;
        if (d !== 32'hFF34FF78) begin
            n_fail++; $display("FAIL strb_read got=%h want=ff34ff78", d);
        end
        axi_write(8'h04, 32'h0, 4'h0, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        n_tests++;
        if (pw !== 8'h02 || ro[63:32] !== 32'h2) begin
            n_fail++; $display("FAIL strb_zero pulse=%h reg1=%h want 02/00000002", pw, ro[63:32]);
        end
    endtask

    task automatic test_ro_range();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        axi_write(8'h18, 32'hA5, 4'hF, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        n_tests++;
        if (r !== 2'b10 || pw !== 8'h00) begin
            n_fail++; $display("FAIL ro_write resp=%b pulse=%h want 10/00", r, pw);
        end
        axi_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'hCAFE || r !== 2'b00) begin
            n_fail++; $display("FAIL ro_read got=%h/%b want=0000cafe/00", d, r);
        end
        axi_read(8'h20, d, r);
        n_tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL oor_read got=%h/%b want=0/10", d, r);
        end
        axi_write(8'h20, 32'h77, 4'hF, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        n_tests++;
        if (r !== 2'b10 || pw !== 8'h00) begin
            n_fail++; $display("FAIL oor_write resp=%b pulse=%h want 10/00", r, pw);
        end
    endtask

    task automatic test_pulse();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        axi_write(8'h14, 32'h1, 4'hF, 0, 5, r, lat, pw, pw2, ro, ro2, st);
        n_tests++;
        if (ro[191:160] !== 32'h1 || ro2[191:160] !== 32'h0) begin
            n_fail++; $display("FAIL pulse_reg got=%h then %h want=1 then 0", ro[191:160], ro2[191:160]);
        end
        n_tests++;
        if (!st || r !== 2'b00) begin
            n_fail++; $display("FAIL bready_hold stable=%0d resp=%b want 1/00", st, r);
        end
        axi_read(8'h14, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL pulse_read got=%h want=0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; int lat; logic [7:0] pw, pw2; logic [255:0] ro, ro2; bit st;
        logic [31:0] d;
        @(negedge ACLK);
        AWADDR = 8'h00; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 8'h00; ARVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        n_tests++;
        if ({BVALID, RVALID} !== 2'b11) begin
            n_fail++; $display("FAIL mid_pending got=%b want=11", {BVALID, RVALID});
        end
        #2 ARESETN = 1'b0;
        #1;
        n_tests++;
        if ({BVALID, RVALID} !== 2'b00 || reg_out !== '0) begin
            n_fail++; $display("FAIL mid_reset valids=%b reg_out=%h want 00/0", {BVALID, RVALID}, reg_out);
        end
        @(negedge ACLK); ARESETN = 1'b1;
        @(negedge ACLK);
        axi_write(8'h04, 32'h55, 4'hF, 0, 0, r, lat, pw, pw2, ro, ro2, st);
        axi_read(8'h04, d, r);
        n_tests++;
        if (d !== 32'h55 || r !== 2'b00) begin
            n_fail++; $display("FAIL after_reset_write got=%h/%b want=00000055/00", d, r);
        end
    endtask

    initial begin
        status_in[6*32 +: 32] = 32'hCAFE;
        test_reset();
        test_basic();
        test_w_first();
        test_strb();
        test_ro_range();
        test_pulse();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
